// File: rtl/imem_arbiter_if.sv
// Bundle of fetch, loader and memory-side signals around the instruction-memory arbiter.
// slave = arbiter view; master = requesters plus memory array view.
interface imem_arbiter_if #(
  parameter int ADDR_W = 10,
  parameter int DATA_W = 32
);
  logic              f_req_valid;
  logic [31:0]       f_req_addr;
  logic              f_req_ready;
  logic              f_rsp_valid;
  logic [DATA_W-1:0] f_rsp_data;

  logic              l_lock;
  logic              l_req_valid;
  logic              l_req_we;
  logic [31:0]       l_req_addr;
  logic [DATA_W-1:0] l_req_wdata;
  logic              l_req_ready;
  logic              l_rsp_valid;
  logic [DATA_W-1:0] l_rsp_data;

  logic              rsp_err;

  logic              mem_en;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;

  modport slave (
    input  f_req_valid, f_req_addr, l_lock, l_req_valid, l_req_we, l_req_addr,
           l_req_wdata, mem_rdata,
    output f_req_ready, f_rsp_valid, f_rsp_data, l_req_ready, l_rsp_valid,
           l_rsp_data, rsp_err, mem_en, mem_we, mem_addr, mem_wdata
  );

  modport master (
    output f_req_valid, f_req_addr, l_lock, l_req_valid, l_req_we, l_req_addr,
           l_req_wdata, mem_rdata,
    input  f_req_ready, f_rsp_valid, f_rsp_data, l_req_ready, l_rsp_valid,
           l_rsp_data, rsp_err, mem_en, mem_we, mem_addr, mem_wdata
  );
endinterface

// File: rtl/imem_arbiter.sv
// Shares a single-port synchronous-read instruction memory between fetch and loader.
// Optional macro IMEM_ALIGN_CHECK_EN: misaligned / out-of-range requests are acked with rsp_err.
module imem_arbiter #(
  parameter int ADDR_W       = 10,
  parameter int DATA_W       = 32,
  parameter int STARVE_LIMIT = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  imem_arbiter_if.slave        bus
);

  localparam int CNT_W = $clog2(STARVE_LIMIT + 1);

  typedef enum logic [1:0] {
    OWN_NONE,
    OWN_FETCH,
    OWN_LOAD_RD
  } owner_e;

  owner_e            owner_q, owner_nxt;
  logic              err_q, err_nxt;
  logic [CNT_W-1:0]  starve_cnt, starve_cnt_nxt;
  logic [DATA_W-1:0] f_hold_q, l_hold_q;
  logic [DATA_W-1:0] rsp_word;
  logic              fetch_grant, load_grant, any_grant, req_err;
  logic [31:0]       win_addr;

`ifdef IMEM_ALIGN_CHECK_EN
  assign req_err = any_grant &&
                   ((win_addr[1:0] != 2'b00) || (|win_addr[31:ADDR_W+2]));
`else
  logic unused_addr_bits;
  assign req_err          = 1'b0;
  assign unused_addr_bits = ^{win_addr[1:0], win_addr[31:ADDR_W+2]};
`endif

  // NOTE: every signal driven here gets a default first so no path can infer a latch.
  always_comb begin
    fetch_grant = 1'b0;
    load_grant  = 1'b0;
    owner_nxt   = OWN_NONE;

    // Loader wins by default; a starved fetch takes the slot unless the loader holds the lock.
    if (bus.f_req_valid && !bus.l_lock &&
        (!bus.l_req_valid || (starve_cnt == CNT_W'(STARVE_LIMIT)))) begin
      fetch_grant = 1'b1;
    end else if (bus.l_req_valid) begin
      load_grant = 1'b1;
    end
    any_grant = fetch_grant || load_grant;
    win_addr  = fetch_grant ? bus.f_req_addr : bus.l_req_addr;

    bus.f_req_ready = fetch_grant;
    bus.l_req_ready = load_grant;
    bus.mem_en      = any_grant && !req_err;
    bus.mem_we      = load_grant && bus.l_req_we && !req_err;
    bus.mem_addr    = win_addr[ADDR_W+1:2];
    bus.mem_wdata   = bus.l_req_wdata;

    // A rejected loader write still owes the loader an error response.
    if (fetch_grant) begin
      owner_nxt = OWN_FETCH;
    end else if (load_grant && (!bus.l_req_we || req_err)) begin
      owner_nxt = OWN_LOAD_RD;
    end
    err_nxt = req_err;

    starve_cnt_nxt = starve_cnt;
    if (bus.l_lock || !bus.f_req_valid || fetch_grant) begin
      starve_cnt_nxt = '0;
    end else if (starve_cnt != CNT_W'(STARVE_LIMIT)) begin
      starve_cnt_nxt = starve_cnt + CNT_W'(1);
    end

    rsp_word        = err_q ? '0 : bus.mem_rdata;
    bus.f_rsp_valid = (owner_q == OWN_FETCH);
    bus.l_rsp_valid = (owner_q == OWN_LOAD_RD);
    bus.f_rsp_data  = bus.f_rsp_valid ? rsp_word : f_hold_q;
    bus.l_rsp_data  = bus.l_rsp_valid ? rsp_word : l_hold_q;
    bus.rsp_err     = err_q && (owner_q != OWN_NONE);
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      owner_q    <= OWN_NONE;
      err_q      <= 1'b0;
      starve_cnt <= '0;
      f_hold_q   <= '0;
      l_hold_q   <= '0;
    end else begin
      owner_q    <= owner_nxt;
      err_q      <= err_nxt;
      starve_cnt <= starve_cnt_nxt;
      if (bus.f_rsp_valid) f_hold_q <= rsp_word;
      if (bus.l_rsp_valid) l_hold_q <= rsp_word;
    end
  end

endmodule

// File: tb/tb_imem_arbiter.sv
// Directed testbench for imem_arbiter: vector table plus starvation, lock and reset sequences.
// Expectations track IMEM_ALIGN_CHECK_EN when the bench is built with it.
module tb_imem_arbiter;

  localparam int ADDR_W = 10;
  localparam int DATA_W = 32;
`ifdef IMEM_ALIGN_CHECK_EN
  localparam bit ALN = 1'b1;
`else
  localparam bit ALN = 1'b0;
`endif

  logic clk;
  logic rst;
  int   checks   = 0;
  int   failures = 0;

  imem_arbiter_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

  imem_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .STARVE_LIMIT(4)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Synchronous-read memory model; word i preloads as 0xA0000000 | i.
  logic [DATA_W-1:0] mem [1024];
  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < 1024; i++) mem[i] <= 32'hA000_0000 | 32'(i);
      bus.mem_rdata <= '0;
    end else if (bus.mem_en) begin
      if (bus.mem_we) mem[bus.mem_addr] <= bus.mem_wdata;
      else            bus.mem_rdata     <= mem[bus.mem_addr];
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  typedef struct {
    logic        fv;   logic [31:0] fa;
    logic        lk;   logic        lv;   logic we;
    logic [31:0] la;   logic [31:0] wd;
    logic        e_fr; logic        e_lr; logic e_en; logic e_we;
    logic [9:0]  e_ma;
    logic        e_fv; logic        e_lv; logic e_err;
    logic [31:0] e_fd; logic [31:0] e_ld;
  } vec_t;

  function automatic vec_t mk(
    logic fv, logic [31:0] fa, logic lv, logic we, logic [31:0] la, logic [31:0] wd,
    logic e_fr, logic e_lr, logic e_en, logic e_we, logic [9:0] e_ma,
    logic e_fv, logic e_lv, logic e_err, logic [31:0] e_fd, logic [31:0] e_ld);
    vec_t v;
    v.fv = fv; v.fa = fa; v.lk = 1'b0; v.lv = lv; v.we = we; v.la = la; v.wd = wd;
    v.e_fr = e_fr; v.e_lr = e_lr; v.e_en = e_en; v.e_we = e_we; v.e_ma = e_ma;
    v.e_fv = e_fv; v.e_lv = e_lv; v.e_err = e_err; v.e_fd = e_fd; v.e_ld = e_ld;
    return v;
  endfunction

  task automatic drive(input logic fv, input logic [31:0] fa, input logic lk, input logic lv,
                       input logic we, input logic [31:0] la, input logic [31:0] wd);
    bus.f_req_valid = fv;  bus.f_req_addr  = fa;
    bus.l_lock      = lk;  bus.l_req_valid = lv;
    bus.l_req_we    = we;  bus.l_req_addr  = la;
    bus.l_req_wdata = wd;
  endtask

  vec_t vecs [10];
  int   grants;
  int   f_seen;
  int   first_f;

  initial begin
    rst = 1'b0;
    drive(0, 0, 0, 0, 0, 0, 0);

    // Vectors are applied at the falling edge, combinational outputs checked 1 time unit later,
    // registered responses checked 1 time unit after the following rising edge.
    //           fv fa           lv we la     wd            fr lr en we ma  fv lv err fd  ld
    vecs[0] = mk(1, 32'h0,       0, 0, 0,     0,            1, 0, 1, 0, 0,  1, 0, 0, 32'hA000_0000, 0);
    vecs[1] = mk(1, 32'h4,       0, 0, 0,     0,            1, 0, 1, 0, 1,  1, 0, 0, 32'hA000_0001, 0);
    vecs[2] = mk(1, 32'h8,       0, 0, 0,     0,            1, 0, 1, 0, 2,  1, 0, 0, 32'hA000_0002, 0);
    vecs[3] = mk(0, 32'h0,       0, 0, 0,     0,            0, 0, 0, 0, 0,  0, 0, 0, 32'hA000_0002, 0);
    vecs[4] = mk(0, 32'h0,       1, 1, 32'h8, 32'h0010_0113, 0, 1, 1, 1, 2, 0, 0, 0, 32'hA000_0002, 0);
    vecs[5] = mk(0, 32'h0,       1, 0, 32'h8, 0,            0, 1, 1, 0, 2,  0, 1, 0, 32'hA000_0002, 32'h0010_0113);
    vecs[6] = mk(1, 32'h1000,    0, 0, 0,     0,            1, 0, !ALN, 0, 0, 1, 0, ALN,
                 ALN ? 32'h0 : 32'hA000_0000, 32'h0010_0113);
    vecs[7] = mk(1, 32'h6,       0, 0, 0,     0,            1, 0, !ALN, 0, 1, 1, 0, ALN,
                 ALN ? 32'h0 : 32'hA000_0001, 32'h0010_0113);
    vecs[8] = mk(1, 32'hC,       1, 0, 32'h10, 0,           0, 1, 1, 0, 4,  0, 1, 0,
                 ALN ? 32'h0 : 32'hA000_0001, 32'hA000_0004);
    vecs[9] = mk(0, 32'h0,       0, 0, 0,     0,            0, 0, 0, 0, 0,  0, 0, 0,
                 ALN ? 32'h0 : 32'hA000_0001, 32'hA000_0004);

    repeat (2) @(negedge clk);
    check("reset_f_rsp_valid", 32'(bus.f_rsp_valid), 0);
    check("reset_l_rsp_valid", 32'(bus.l_rsp_valid), 0);
    check("reset_rsp_err",     32'(bus.rsp_err),     0);
    check("reset_f_rsp_data",  bus.f_rsp_data,       0);
    check("reset_l_rsp_data",  bus.l_rsp_data,       0);
    rst = 1'b1;
    @(negedge clk);

    for (int i = 0; i < 10; i++) begin
      drive(vecs[i].fv, vecs[i].fa, vecs[i].lk, vecs[i].lv, vecs[i].we, vecs[i].la, vecs[i].wd);
      #1;
      check($sformatf("v%0d_f_ready", i), 32'(bus.f_req_ready), 32'(vecs[i].e_fr));
      check($sformatf("v%0d_l_ready", i), 32'(bus.l_req_ready), 32'(vecs[i].e_lr));
      check($sformatf("v%0d_mem_en",  i), 32'(bus.mem_en),      32'(vecs[i].e_en));
      if (vecs[i].e_en) check($sformatf("v%0d_mem_we", i), 32'(bus.mem_we), 32'(vecs[i].e_we));
      if (vecs[i].e_fr || vecs[i].e_lr)
        check($sformatf("v%0d_mem_addr", i), 32'(bus.mem_addr), 32'(vecs[i].e_ma));
      @(posedge clk); #1;
      check($sformatf("v%0d_f_rsp_valid", i), 32'(bus.f_rsp_valid), 32'(vecs[i].e_fv));
      check($sformatf("v%0d_l_rsp_valid", i), 32'(bus.l_rsp_valid), 32'(vecs[i].e_lv));
      check($sformatf("v%0d_rsp_err",     i), 32'(bus.rsp_err),     32'(vecs[i].e_err));
      check($sformatf("v%0d_f_rsp_data",  i), bus.f_rsp_data,       vecs[i].e_fd);
      check($sformatf("v%0d_l_rsp_data",  i), bus.l_rsp_data,       vecs[i].e_ld);
      @(negedge clk);
    end

    // Starvation: both requesting continuously gives L,L,L,L,F repeating.
    drive(1, 32'h20, 0, 1, 0, 32'h24, 0);
    for (int i = 0; i < 15; i++) begin
      #1;
      check($sformatf("starve%0d_f_ready", i), 32'(bus.f_req_ready), 32'((i % 5) == 4));
      check($sformatf("starve%0d_l_ready", i), 32'(bus.l_req_ready), 32'((i % 5) != 4));
      @(posedge clk); #1;
      if (i == 4) check("starve_f_rsp_data", bus.f_rsp_data, 32'hA000_0008);
      @(negedge clk);
    end

    // Lock: fetch never granted, loader granted every cycle.
    grants = 0;
    f_seen = 0;
    drive(1, 32'h20, 1, 1, 0, 32'h24, 0);
    for (int i = 0; i < 20; i++) begin
      #1;
      if (bus.f_req_ready) f_seen++;
      if (bus.l_req_ready) grants++;
      @(negedge clk);
    end
    check("lock_f_ready_seen", 32'(f_seen), 0);
    check("lock_l_grants",     32'(grants), 20);

    drive(1, 32'h20, 1, 0, 0, 0, 0);
    #1;
    check("lock_fetch_only_ready",  32'(bus.f_req_ready), 0);
    check("lock_fetch_only_mem_en", 32'(bus.mem_en),      0);
    @(negedge clk);

    // Lock released with loader still requesting: starvation count restarts from zero.
    drive(1, 32'h20, 0, 1, 0, 32'h24, 0);
    first_f = -1;
    for (int i = 0; i < 10; i++) begin
      #1;
      if (first_f < 0 && bus.f_req_ready) first_f = i;
      @(negedge clk);
    end
    check("unlock_first_fetch_cycle", 32'(first_f), 32'd4);

    // Asynchronous reset while a fetch response is on the bus.
    drive(0, 0, 0, 0, 0, 0, 0);
    @(negedge clk);
    drive(1, 32'h0, 0, 0, 0, 0, 0);
    #1;
    check("rst_seq_f_ready", 32'(bus.f_req_ready), 1);
    @(posedge clk); #1;
    check("rst_seq_f_rsp_valid_pre", 32'(bus.f_rsp_valid), 1);
    drive(0, 0, 0, 0, 0, 0, 0);
    rst = 1'b0;
    #1;
    check("rst_seq_f_rsp_valid", 32'(bus.f_rsp_valid), 0);
    check("rst_seq_f_rsp_data",  bus.f_rsp_data,       0);
    check("rst_seq_l_rsp_data",  bus.l_rsp_data,       0);
    check("rst_seq_rsp_err",     32'(bus.rsp_err),     0);
    @(posedge clk); #1;
    check("rst_seq_f_rsp_valid_hold", 32'(bus.f_rsp_valid), 0);
    check("rst_seq_l_rsp_valid_hold", 32'(bus.l_rsp_valid), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
